// File: rtl/usb_tx_packetizer.sv
// Low-speed USB transmit packet sequencer: arbitrates handshake and data requests, emits
// PID / payload / CRC16 bytes to the serializer, tracks DATA0/DATA1 and enforces the inter-packet gap.
module usb_tx_packetizer #(
    parameter int MAX_LEN  = 8,
    parameter int IPG_CLKS = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hs_req_i,
    input  logic [1:0] hs_pid_i,
    output logic       hs_ack_o,
    input  logic       dat_req_i,
    input  logic [3:0] dat_len_i,
    output logic       dat_ack_o,
    output logic [2:0] buf_addr_o,
    input  logic [7:0] buf_rdata_i,
    input  logic       toggle_clr_i,
    input  logic       toggle_adv_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       done_o
);

    localparam int GW = (IPG_CLKS > 1) ? $clog2(IPG_CLKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PID     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CRC_LO  = 3'd3,
        S_CRC_HI  = 3'd4,
        S_FLUSH   = 3'd5,
        S_GAP     = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [2:0]    buf_addr_q, buf_addr_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    len_q, len_d;
    logic          is_dat_q, is_dat_d;
    logic [15:0]   crc_q, crc_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          toggle_q, toggle_d;
    logic          busy_q, busy_d;
    logic          hs_ack_q, hs_ack_d;
    logic          dat_ack_q, dat_ack_d;
    logic          done_q, done_d;
    logic [15:0]   crc_nxt_s;
    logic [3:0]    len_clamped_s;

    // Reflected CRC16 (x^16+x^15+x^2+1), one byte processed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = {1'b0, c[15:1]} ^ 16'hA001;
            end else begin
                c = {1'b0, c[15:1]};
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] hs_pid_byte(input logic [1:0] code);
        logic [7:0] b;
        case (code)
            2'b00:   b = 8'hD2;
            2'b01:   b = 8'h5A;
            2'b10:   b = 8'h1E;
            default: b = 8'h5A;
        endcase
        return b;
    endfunction

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            buf_addr_q <= 3'd0;
            idx_q      <= 4'd0;
            len_q      <= 4'd0;
            is_dat_q   <= 1'b0;
            crc_q      <= 16'hFFFF;
            gap_q      <= '0;
            toggle_q   <= 1'b0;
            busy_q     <= 1'b0;
            hs_ack_q   <= 1'b0;
            dat_ack_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            buf_addr_q <= buf_addr_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            is_dat_q   <= is_dat_d;
            crc_q      <= crc_d;
            gap_q      <= gap_d;
            toggle_q   <= toggle_d;
            busy_q     <= busy_d;
            hs_ack_q   <= hs_ack_d;
            dat_ack_q  <= dat_ack_d;
            done_q     <= done_d;
        end
    end

    // Next-state, byte sequencing, CRC and toggle logic.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        buf_addr_d = buf_addr_q;
        idx_d      = idx_q;
        len_d      = len_q;
        is_dat_d   = is_dat_q;
        crc_d      = crc_q;
        gap_d      = gap_q;
        busy_d     = busy_q;
        hs_ack_d   = 1'b0;
        dat_ack_d  = 1'b0;
        done_d     = 1'b0;
        crc_nxt_s  = crc16_byte(crc_q, tx_data_q);

        if (dat_len_i > 4'(MAX_LEN)) begin
            len_clamped_s = 4'(MAX_LEN);
        end else begin
            len_clamped_s = dat_len_i;
        end

        // The PID is latched at accept, so toggle changes only reach the next packet.
        if (toggle_clr_i) begin
            toggle_d = 1'b0;
        end else if (toggle_adv_i) begin
            toggle_d = ~toggle_q;
        end else begin
            toggle_d = toggle_q;
        end

        case (state_q)
            S_IDLE: begin
                if (hs_req_i) begin
                    hs_ack_d   = 1'b1;
                    is_dat_d   = 1'b0;
                    tx_data_d  = hs_pid_byte(hs_pid_i);
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    crc_d      = 16'hFFFF;
                    buf_addr_d = 3'd0;
                    idx_d      = 4'd0;
                    state_d    = S_PID;
                end else if (dat_req_i) begin
                    dat_ack_d  = 1'b1;
                    is_dat_d   = 1'b1;
                    len_d      = len_clamped_s;
                    tx_data_d  = toggle_q ? 8'h4B : 8'hC3;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    crc_d      = 16'hFFFF;
                    buf_addr_d = 3'd0;
                    idx_d      = 4'd0;
                    state_d    = S_PID;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PID: begin
                if (!tx_ready_i) begin
                    state_d = S_PID;
                end else if (!is_dat_q) begin
                    state_d = S_FLUSH;
                end else if (len_q == 4'd0) begin
                    tx_data_d = ~crc_q[7:0];
                    state_d   = S_CRC_LO;
                end else begin
                    // buf_rdata already holds byte 0, addressed at accept.
                    tx_data_d  = buf_rdata_i;
                    buf_addr_d = 3'd1;
                    idx_d      = 4'd1;
                    state_d    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!tx_ready_i) begin
                    state_d = S_PAYLOAD;
                end else if (idx_q == len_q) begin
                    crc_d     = crc_nxt_s;
                    tx_data_d = ~crc_nxt_s[7:0];
                    state_d   = S_CRC_LO;
                end else begin
                    crc_d      = crc_nxt_s;
                    tx_data_d  = buf_rdata_i;
                    buf_addr_d = idx_q[2:0] + 3'd1;
                    idx_d      = idx_q + 4'd1;
                    state_d    = S_PAYLOAD;
                end
            end
            S_CRC_LO: begin
                if (tx_ready_i) begin
                    tx_data_d = ~crc_q[15:8];
                    state_d   = S_CRC_HI;
                end else begin
                    state_d = S_CRC_LO;
                end
            end
            S_CRC_HI: begin
                if (tx_ready_i) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_CRC_HI;
                end
            end
            S_FLUSH: begin
                if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    gap_d      = '0;
                    state_d    = S_GAP;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(IPG_CLKS - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_d   = gap_q + GW'(1);
                    state_d = S_GAP;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    assign hs_ack_o   = hs_ack_q;
    assign dat_ack_o  = dat_ack_q;
    assign buf_addr_o = buf_addr_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Table-driven bench for usb_tx_packetizer with a serializer model, payload RAM model
// and an independent (non-reflected) CRC16 reference.
module tb_usb_tx_packetizer;

    localparam int IPG     = 128;
    localparam int SPACING = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic       hs_req, dat_req, toggle_clr, toggle_adv, tx_ready;
    logic [1:0] hs_pid;
    logic [3:0] dat_len;
    logic       hs_ack, dat_ack, tx_valid, busy, done;
    logic [2:0] buf_addr;
    logic [7:0] buf_rdata, tx_data;
    logic [7:0] buf_mem [8];

    always #5 clk = ~clk;

    usb_tx_packetizer dut (
        .clk          (clk),
        .reset        (reset),
        .hs_req_i     (hs_req),
        .hs_pid_i     (hs_pid),
        .hs_ack_o     (hs_ack),
        .dat_req_i    (dat_req),
        .dat_len_i    (dat_len),
        .dat_ack_o    (dat_ack),
        .buf_addr_o   (buf_addr),
        .buf_rdata_i  (buf_rdata),
        .toggle_clr_i (toggle_clr),
        .toggle_adv_i (toggle_adv),
        .tx_data_o    (tx_data),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    // Synchronous-read payload RAM.
    always @(posedge clk) buf_rdata <= buf_mem[buf_addr];

    typedef struct {
        logic       hs;
        logic [1:0] pid;
        logic       dat;
        logic [3:0] len;
        logic [7:0] base;
        logic [1:0] tog;      // [0] adv pulse, [1] clr pulse, before the request
        logic       mid_adv;
        int         exp_n;
        logic [7:0] exp_pid;
    } vec_t;

    vec_t       vecs [12];
    int         checks = 0;
    int         errors = 0;
    int         cur_vec = -1;
    int         pulses, hs_acks, dat_acks, gap_cnt, busy_err, both_ack, done_extra, first_ack;
    bit         timed_out;
    logic [7:0] cap_b [16];
    logic [7:0] exp_b [16];
    int         exp_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL v%0d %s: got %0h want %0h", cur_vec, name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_norm(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    task automatic build_exp(input logic [7:0] pid_b, input logic is_dat, input logic [3:0] len);
        logic [15:0] c, r;
        int          n_pay;
        n_pay    = (len > 4'd8) ? 8 : int'(len);
        exp_b[0] = pid_b;
        exp_n    = 1;
        if (is_dat) begin
            c = 16'hFFFF;
            for (int i = 0; i < n_pay; i++) begin
                exp_b[exp_n] = buf_mem[i];
                c = crc_norm(c, buf_mem[i]);
                exp_n++;
            end
            for (int i = 0; i < 16; i++) r[i] = c[15-i];
            r = ~r;
            exp_b[exp_n]     = r[7:0];
            exp_b[exp_n + 1] = r[15:8];
            exp_n += 2;
        end
    endtask

    task automatic clear_counts();
        hs_acks = 0; dat_acks = 0; both_ack = 0; first_ack = 0;
    endtask

    // Drives requests, models the serializer and watches one packet through to done.
    task automatic run_packet(input logic hs, input logic [1:0] pid, input logic dat,
                              input logic [3:0] len, input logic mid_adv, input int rst_pulse);
        int since;
        bit started, fell, fin, rst_phase, by_done;
        pulses = 0; gap_cnt = 0; busy_err = 0; done_extra = 0;
        since = 0; started = 0; fell = 0; fin = 0; rst_phase = 0; by_done = 0;
        for (int i = 0; i < 16; i++) cap_b[i] = 8'h00;
        if (hs) begin hs_pid = pid; hs_req = 1'b1; end
        if (dat) begin dat_len = len; dat_req = 1'b1; end
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            tx_ready   = 1'b0;
            toggle_adv = 1'b0;
            if (hs_ack && dat_ack) both_ack++;
            if (hs_ack) begin hs_acks++; hs_req = 1'b0; if (first_ack == 0) first_ack = 1; end
            if (dat_ack) begin dat_acks++; dat_req = 1'b0; if (first_ack == 0) first_ack = 2; end
            if (by_done) begin
                done_extra = int'(done);
                fin = 1;
            end else if (rst_phase) begin
                chk("rst_tx_valid", tx_valid, 0);
                chk("rst_busy", busy, 0);
                reset = 1'b0;
                fin = 1;
            end else if (rst_pulse != 0 && pulses == rst_pulse && since == 3) begin
                reset = 1'b1;
                rst_phase = 1;
            end else begin
                if (started && !tx_valid) fell = 1;
                if (done) begin
                    by_done = 1;
                    if (busy) busy_err++;
                end else if (fell) begin
                    gap_cnt++;
                end
                if (tx_valid) begin
                    started = 1;
                    if (!busy) busy_err++;
                    since++;
                    if (since >= SPACING) begin
                        since    = 0;
                        tx_ready = 1'b1;
                        if (pulses < 16) cap_b[pulses] = tx_data;
                        pulses++;
                        if (mid_adv && pulses == 2) toggle_adv = 1'b1;
                    end
                end
            end
        end
        timed_out = !fin;
    endtask

    task automatic check_packet(input logic is_dat, input int exp_hs, input int exp_dat);
        logic [15:0] c;
        chk("timeout", 32'(timed_out), 0);
        chk("pulses", pulses, exp_n + 1);
        for (int i = 0; i < exp_n; i++) chk($sformatf("byte%0d", i), cap_b[i], exp_b[i]);
        chk("hs_ack_cnt", hs_acks, exp_hs);
        chk("dat_ack_cnt", dat_acks, exp_dat);
        chk("both_ack", both_ack, 0);
        chk("gap", gap_cnt, IPG);
        chk("busy", busy_err, 0);
        chk("done_once", done_extra, 0);
        if (is_dat) begin
            c = 16'hFFFF;
            for (int i = 1; i < exp_n; i++) c = crc_norm(c, cap_b[i]);
            chk("residue", c, 16'h800D);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             hs    pid    dat   len   base   tog    mid   n   pid byte
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 4'd0,  8'h00, 2'b00, 1'b0, 1,  8'hD2};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 4'd0,  8'h00, 2'b00, 1'b0, 3,  8'hC3};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 4'd8,  8'h00, 2'b00, 1'b0, 11, 8'hC3};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 4'd0,  8'h00, 2'b00, 1'b0, 1,  8'h5A};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, 4'd0,  8'h00, 2'b00, 1'b0, 1,  8'h1E};
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 4'd0,  8'h00, 2'b00, 1'b0, 1,  8'h5A};
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 4'd3,  8'hA0, 2'b01, 1'b0, 6,  8'h4B};
        vecs[7]  = '{1'b0, 2'b00, 1'b1, 4'd1,  8'h55, 2'b10, 1'b0, 4,  8'hC3};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 4'd15, 8'h10, 2'b11, 1'b0, 11, 8'hC3};
        vecs[9]  = '{1'b0, 2'b00, 1'b1, 4'd5,  8'hF8, 2'b01, 1'b1, 8,  8'h4B};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 4'd2,  8'h33, 2'b00, 1'b0, 5,  8'hC3};
        vecs[11] = '{1'b1, 2'b00, 1'b0, 4'd0,  8'h00, 2'b00, 1'b0, 1,  8'hD2};

        reset = 1'b1; hs_req = 1'b0; dat_req = 1'b0; hs_pid = 2'b00; dat_len = 4'd0;
        toggle_clr = 1'b0; toggle_adv = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) buf_mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        chk("reset_outs", {tx_valid, busy, done, hs_ack, dat_ack, buf_addr, tx_data}, 0);
        reset = 1'b0;

        // tx_ready while idle must not start anything
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); tx_ready = 1'b1;
            @(negedge clk); tx_ready = 1'b0;
        end
        chk("idle_ready", {tx_valid, busy, hs_ack, dat_ack}, 0);

        for (int v = 0; v < 12; v++) begin
            cur_vec = v;
            for (int i = 0; i < 8; i++) buf_mem[i] = vecs[v].base + 8'(i);
            @(negedge clk);
            toggle_adv = vecs[v].tog[0];
            toggle_clr = vecs[v].tog[1];
            @(negedge clk);
            toggle_adv = 1'b0;
            toggle_clr = 1'b0;
            chk("exp_n", exp_n_of(vecs[v]), vecs[v].exp_n);
            build_exp(vecs[v].exp_pid, vecs[v].dat, vecs[v].len);
            clear_counts();
            run_packet(vecs[v].hs, vecs[v].pid, vecs[v].dat, vecs[v].len, vecs[v].mid_adv, 0);
            check_packet(vecs[v].dat, vecs[v].hs ? 1 : 0, vecs[v].dat ? 1 : 0);
        end

        // Reset mid-payload with toggle at DATA1
        cur_vec = 100;
        for (int i = 0; i < 8; i++) buf_mem[i] = 8'(i);
        @(negedge clk); toggle_adv = 1'b1;
        @(negedge clk); toggle_adv = 1'b0;
        clear_counts();
        run_packet(1'b0, 2'b00, 1'b1, 4'd8, 1'b0, 4);
        chk("rst_pid", cap_b[0], 8'h4B);
        chk("rst_byte1", cap_b[2], 8'h01);
        chk("rst_pulses", pulses, 4);
        chk("rst_dat_ack", dat_acks, 1);

        // Both requests in one cycle: handshake wins, data follows after the gap
        cur_vec = 101;
        build_exp(8'hD2, 1'b0, 4'd0);
        clear_counts();
        run_packet(1'b1, 2'b00, 1'b1, 4'd2, 1'b0, 0);
        check_packet(1'b0, 1, 1);
        chk("arb_first", first_ack, 1);
        cur_vec = 102;
        build_exp(8'hC3, 1'b1, 4'd2);
        clear_counts();
        run_packet(1'b0, 2'b00, 1'b0, 4'd2, 1'b0, 0);
        check_packet(1'b1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic int exp_n_of(input vec_t v);
        if (v.hs) return 1;
        return 3 + ((v.len > 4'd8) ? 8 : int'(v.len));
    endfunction

endmodule
